// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter sharing the transceiver's single send port among NUM_REQ producers.
// Defining TX_ARB_TIMEOUT_EN compiles in an abort after TIMEOUT_CYCLES cycles of waiting for done.
module tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           data_send,
  output logic                        data_send_valid,
  input  logic                        data_send_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        tx_timeout
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  // Handshake: requester i's word is taken on a cycle with req_valid[i] & req_ready[i];
  // req_ready is raised only in IDLE and only for the round-robin winner.
  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_id;
  logic [IW-1:0] cand;
  logic [IW-1:0] next_ptr;
  logic          any_valid;
  logic          accept;
  logic          wait_exit;
  logic          timeout_hit;
  int            idx;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win_id    = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx  = (int'(rr_ptr) + k) % NUM_REQ;
      cand = IW'(idx);
      if (req_valid[cand]) begin
        win_id    = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && any_valid) req_ready[win_id] = 1'b1;
  end

  assign accept   = (state == ST_IDLE) && any_valid;
  assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state == ST_LAUNCH) || (state == ST_WAIT);

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                   wait_cnt <= '0;
    else if (state == ST_LAUNCH) wait_cnt <= '0;
    else if (state == ST_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // A done arriving on the terminal count wins over the abort.
  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) && !data_send_done;
`else
  assign timeout_hit = 1'b0;
`endif

  assign wait_exit = (state == ST_WAIT) && (data_send_done || timeout_hit);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      data_send       <= '0;
      data_send_valid <= 1'b0;
      grant_id        <= '0;
      tx_timeout      <= 1'b0;
    end else begin
      data_send_valid <= 1'b0;
      tx_timeout      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_send       <= req_data[win_id*DATA_W +: DATA_W];
            grant_id        <= win_id;
            data_send_valid <= 1'b1;
            state           <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= ST_WAIT;
        ST_WAIT: begin
          if (wait_exit) begin
            state      <= ST_IDLE;
            rr_ptr     <= next_ptr;
            tx_timeout <= timeout_hit;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed and randomized bench for tx_arbiter with a round-robin reference model.
// Timeout checks run only when TX_ARB_TIMEOUT_EN is defined.
module tb_tx_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DW      = 16;
  localparam int TO_CYC  = 16;
  localparam int IW      = $clog2(NUM_REQ);

  logic                   clk = 1'b0;
  logic                   rstb = 1'b0;
  logic [NUM_REQ*DW-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DW-1:0]          data_send;
  logic                   data_send_valid;
  logic                   data_send_done = 1'b0;
  logic [IW-1:0]          grant_id;
  logic                   busy;
  logic                   tx_timeout;

  tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DW), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rstb(rstb), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .data_send(data_send), .data_send_valid(data_send_valid), .data_send_done(data_send_done),
    .grant_id(grant_id), .busy(busy), .tx_timeout(tx_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] words [NUM_REQ];
  logic [DW-1:0] exp_q [$];
  int n_assert  = 0;
  int n_fail    = 0;
  int model_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester at or after the pointer, wrapping.
  function automatic int model_winner(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (model_ptr + k) % NUM_REQ;
      if (v[IW'(j)]) return j;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    words[i] = w;
    req_data[i*DW +: DW] = w;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(data_send_valid), 0);
    chk({tag, "_tmo"}, 32'(tx_timeout), 0);
  endtask

  // Called in IDLE just after an edge; returns in IDLE just after the edge following done.
  task automatic do_txn(input logic [NUM_REQ-1:0] vmask, input int delay, input bit wiggle,
                        input bit spur, output int lcyc);
    int w;
    req_valid = vmask;
    #1;
    w = model_winner(vmask);
    chk("ready_idle", 32'(req_ready), 32'(1) << w);
    exp_q.push_back(words[w]);
    tick();
    lcyc = cyc;
    if (spur) data_send_done = 1'b1;
    chk("launch_valid", 32'(data_send_valid), 1);
    chk("launch_data", 32'(data_send), 32'(exp_q.pop_front()));
    chk("launch_grant", 32'(grant_id), w);
    chk("launch_busy", 32'(busy), 1);
    chk("launch_ready", 32'(req_ready), 0);
    repeat (delay) begin
      tick();
      data_send_done = 1'b0;
      if (wiggle) req_valid = NUM_REQ'($urandom);
      #1;
      chk("wait_busy", 32'(busy), 1);
      chk("wait_valid", 32'(data_send_valid), 0);
      chk("wait_ready", 32'(req_ready), 0);
    end
    data_send_done = 1'b1;
    tick();
    data_send_done = 1'b0;
    check_quiet("done");
    chk("hold_data", 32'(data_send), 32'(words[w]));
    chk("hold_grant", 32'(grant_id), w);
    model_ptr = (w + 1) % NUM_REQ;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lc;
    int prev;
    int w;
    for (int i = 0; i < NUM_REQ; i++) set_word(i, '0);

    tick();
    tick();
    check_quiet("rst");
    chk("rst_data", 32'(data_send), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rstb = 1'b1;
    tick();

    // Fairness: two persistent requesters, done 5 cycles after each launch.
    set_word(0, 16'h1111);
    set_word(1, 16'h2222);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_txn(3'b011, 5, 1'b0, 1'b0, lc);
      chk("fair_order", 32'(data_send), (i % 2) ? 32'h2222 : 32'h1111);
      if (i > 0) chk("fair_gap", 32'(lc - prev), 7);
      prev = lc;
    end

    // Single request with a spurious done during LAUNCH.
    set_word(0, 16'hBEEF);
    do_txn(3'b001, 3, 1'b0, 1'b1, lc);
    chk("single_data", 32'(data_send), 32'hBEEF);

    // Spurious done in IDLE changes nothing.
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      data_send_done = 1'b1;
      tick();
      data_send_done = 1'b0;
      check_quiet("idle_spur");
      chk("idle_spur_ready", 32'(req_ready), 0);
    end

    // Wrap: pointer 2 with requesters 0 and 2 valid.
    set_word(1, 16'hA1A1);
    set_word(2, 16'hC3C3);
    set_word(0, 16'h0F0F);
    do_txn(3'b010, 1, 1'b0, 1'b0, lc);
    do_txn(3'b101, 2, 1'b0, 1'b0, lc);
    chk("wrap_first", 32'(grant_id), 2);
    do_txn(3'b101, 2, 1'b0, 1'b0, lc);
    chk("wrap_second", 32'(grant_id), 0);

    // Reset two cycles after launch with done never sent; pointer restarts at 0.
    do_txn(3'b001, 1, 1'b0, 1'b0, lc);
    set_word(1, 16'h5A5A);
    req_valid = 3'b010;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'b010);
    exp_q.push_back(words[1]);
    tick();
    chk("rst_mid_launch", 32'(data_send), 32'(exp_q.pop_front()));
    tick();
    tick();
    rstb = 1'b0;
    #1;
    check_quiet("rst_mid");
    chk("rst_mid_data", 32'(data_send), 0);
    chk("rst_mid_grant", 32'(grant_id), 0);
    req_valid = 3'b101;
    #1;
    chk("rst_mid_rr", 32'(req_ready), 32'b001);
    req_valid = '0;
    tick();
    tick();
    rstb = 1'b1;
    model_ptr = 0;
    tick();
    check_quiet("post_rst");
    do_txn(3'b101, 1, 1'b0, 1'b0, lc);
    chk("post_rst_grant", 32'(grant_id), 0);

`ifdef TX_ARB_TIMEOUT_EN
    // Done withheld: abort pulse 16 cycles after WAIT entry, pointer advances.
    set_word(2, 16'h7E57);
    req_valid = 3'b110;
    #1;
    w = model_winner(3'b110);
    chk("to_ready", 32'(req_ready), 32'(1) << w);
    tick();
    chk("to_launch", 32'(data_send), 32'(words[w]));
    req_valid = '0;
    for (int i = 1; i <= TO_CYC; i++) begin
      tick();
      chk("to_quiet", 32'(tx_timeout), 0);
      chk("to_busy", 32'(busy), 1);
    end
    tick();
    chk("to_pulse", 32'(tx_timeout), 1);
    chk("to_idle", 32'(busy), 0);
    model_ptr = (w + 1) % NUM_REQ;
    tick();
    chk("to_once", 32'(tx_timeout), 0);
`else
    w = 0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 25; i++) begin
      for (int r = 0; r < NUM_REQ; r++) set_word(r, DW'($urandom));
      do_txn(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), $urandom_range(1, 6),
             1'($urandom), 1'($urandom), lc);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = '0;
        data_send_done = 1'($urandom);
        tick();
        data_send_done = 1'b0;
        check_quiet("rand_gap");
      end
    end

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares the transceiver's single 16-bit send port between several word producers, such as the compute core's result stream and a debug/status echo. It accepts one word at a time over a valid/ready handshake and launches it with a one-cycle `data_send_valid` pulse. It then holds the port until the transceiver returns `data_send_done`. It sits between the producers and the transceiver's `data_send`, `data_send_valid` and `data_send_done` pins.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `DATA_W`, 16: word width; must equal the transceiver word width.
- `TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT before abort. Used only when the timeout is compiled in.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rstb`  in  1: asynchronous, active-low reset.
- `req_data`  in  NUM_REQ*DATA_W: requester i's word is at bits [i*DATA_W +: DATA_W].
- `req_valid`  in  NUM_REQ: requester i has a word.
- `req_ready`  out  NUM_REQ: one-hot; the word is accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `data_send`  out  DATA_W: word to the transceiver.
- `data_send_valid`  out  1: one-cycle launch pulse.
- `data_send_done`  in  1: one-cycle pulse from the transceiver when the word has been fully serialized.
- `grant_id`  out  $clog2(NUM_REQ): index of the requester that owns the port.
- `busy`  out  1: high in LAUNCH and WAIT.
- `tx_timeout`  out  1: one-cycle pulse when a word is aborted.

## Operation
States and transitions:
- IDLE → LAUNCH when any `req_valid` is set.
- LAUNCH → WAIT unconditionally.
- WAIT → IDLE on `data_send_done`, or on timeout.

Arbitration:
- The winner is the first set `req_valid` bit at or after pointer `rr_ptr`, searching upward with wrap from NUM_REQ-1 to 0.
- In IDLE, `req_ready` is combinational: only the winner's bit is set. All bits are 0 in every other state.
- On accept, register the word into `data_send`, register the winner into `grant_id`, and go to LAUNCH.
- On leaving WAIT, set `rr_ptr` to (`grant_id`+1) mod NUM_REQ. This applies to both completion and abort.

Hold and ignore rules:
- `data_send` and `grant_id` hold their values after the word completes, until the next accept.
- `data_send_done` is ignored in IDLE and LAUNCH. It is not stored.
- Any change to `req_valid` outside IDLE is ignored.
- Requesters must hold `req_data` and `req_valid` until accepted.

Reset values:
- State IDLE, `rr_ptr` 0.
- `data_send` 0, `data_send_valid` 0, `grant_id` 0, `busy` 0, `tx_timeout` 0.
- `req_ready` follows the IDLE rule.

Reset mid-operation: asserting `rstb` in any state returns everything to reset values immediately. The in-flight word is dropped, and no done or timeout is reported for it.

## Timing
- Accept at cycle N: `data_send_valid` is 1 in cycle N+1 only, and `busy` is 1 from N+1.
- `data_send_done` sampled at cycle M in WAIT: state is IDLE at M+1 and `busy` is 0 at M+1. The next accept is possible at M+1, with the next launch at M+2.
- Minimum spacing between launch pulses is 3 cycles, counting from the first launch to done being returned the following cycle.
- `data_send_done` arriving in the same cycle as `data_send_valid` is ignored. It belongs to LAUNCH.

## Configuration
- With `TX_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 with no done, pulse `tx_timeout` for one cycle and leave WAIT for IDLE on the next edge.
  - `data_send_done` in that same cycle takes precedence: the word completes and no timeout is reported.
- Without `TX_ARB_TIMEOUT_EN`:
  - No counter exists; WAIT waits indefinitely.
  - `tx_timeout` is tied to 0.

## Test plan
- Single request: req 0 sends 0xBEEF → `req_ready[0]` is high in the same cycle, `data_send`=0xBEEF with a one-cycle valid pulse next cycle, `busy` drops 1 cycle after done, `grant_id`=0.
- Fairness: both requesters hold valid with words 0x1111 and 0x2222 and done returns 5 cycles after each launch → send order is 0x1111, 0x2222, 0x1111, 0x2222; the second launch comes exactly 7 cycles after the first.
- Wrap: NUM_REQ=3, `rr_ptr`=2 with requesters 0 and 2 valid → 2 is granted first, then 0.
- Spurious done: pulse `data_send_done` in IDLE and in LAUNCH → no state change, and the real done is still required.
- Reset: assert `rstb` low 2 cycles after launch, then release with the done pulse never sent → all outputs at reset values, and the next request is granted from pointer 0.
- Timeout (`TX_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16), done withheld → `tx_timeout` pulses 16 cycles after WAIT entry, state returns to IDLE, and the pointer advances.
